wash_motor_seq: RTL
===================

Name: wash_motor_seq

Overview:
- Sequences the PWM generator through a fixed wash program: WASH, then RINSE, then SPIN.
- Drives the generator's enable and 16-bit value inputs, with soft ramps between speed targets.
- Sits between the MCU-facing control/command logic and the PWM generator instance.
- Guarantees the value word is never 0 while enable is high, because the generator divides by it.

Parameters:
- TICK_DIV, 100000: i_clk cycles per timebase tick (1 ms at 100 MHz).
- RAMP_STEP, 10: value increment/decrement per ramp step.
- RAMP_TICKS, 1: ticks between ramp steps.
- MIN_VAL, 1: floor value while enabled; ramp start/end point.
- WASH_VAL, 200: WASH target value.
- RINSE_VAL, 300: RINSE target value.
- SPIN_VAL, 1000: SPIN target value.
- WASH_TICKS, 20000: RUN duration of WASH, in ticks.
- RINSE_TICKS, 20000: RUN duration of RINSE, in ticks.
- SPIN_TICKS, 30000: RUN duration of SPIN, in ticks.
- REV_TICKS, 5000: WASH reversal interval in ticks (optional feature only).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  1-cycle pulse; begins program from IDLE.
- i_stop  in  1  1-cycle pulse; abort with ramp-down.
- i_pause  in  1  level; freezes program and gates motor.
- o_pwm_en  out  1  to PWM generator i_en.
- o_pwm_value  out  16  to PWM generator i_value.
- o_phase  out  2  0=WASH, 1=RINSE, 2=SPIN.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  1-cycle pulse on normal completion.
- o_dir  out  1  motor direction (optional feature).

Behaviour:
- Reset (async, active-high): state IDLE; o_pwm_en=0, o_pwm_value=0, o_phase=0, o_busy=0, o_done=0, o_dir=0; all counters cleared.
- Tick: divider counts 0..TICK_DIV-1 only when busy and not frozen; emits a 1-cycle tick at TICK_DIV-1. Cleared on entry to IDLE.
- States: IDLE, RAMP, RUN, STOP_RAMP, DONE.
- IDLE -> RAMP on i_start with i_stop=0. Cycle after: o_pwm_value=MIN_VAL, o_phase=0, target=WASH_VAL. i_start and i_stop in the same cycle: stay IDLE. i_start while busy: ignored.
- RAMP:
  - Every RAMP_TICKS ticks, value moves toward target by RAMP_STEP.
  - If |target-value| <= RAMP_STEP, value=target. Never overshoots.
  - Compute in 17 bits, so no wrap at 0xFFFF.
  - When value==target -> RUN, loading the phase timer with the phase's *_TICKS.
- RUN:
  - Phase timer decrements on each tick.
  - The tick that takes it to 0 ends the phase: exactly *_TICKS ticks in RUN.
  - WASH/RINSE end -> RAMP, with o_phase+1 and the next target. Ramps directly between targets, up or down.
  - SPIN end -> STOP_RAMP.
- STOP_RAMP: ramps toward MIN_VAL under the same rules. At MIN_VAL -> DONE (normal completion) or IDLE (abort).
- DONE: one cycle; o_done=1; o_pwm_en=0, o_pwm_value=0; -> IDLE.
- i_stop in RAMP or RUN: -> STOP_RAMP, marked abort; no o_done pulse. i_stop in STOP_RAMP/DONE/IDLE: ignored.
- i_pause (RAMP/RUN only):
  - Freezes divider, ramp and phase timers.
  - o_pwm_en=0, o_pwm_value held.
  - On release, resumes exactly where it froze.
- i_pause is ignored in STOP_RAMP (abort/finish always completes) and in IDLE.
- o_pwm_en=1 exactly when state is RAMP/RUN/STOP_RAMP and not paused. Whenever o_pwm_en=1, o_pwm_value>=MIN_VAL (clamped).
- All outputs are registered; state-change effects appear one cycle after the causing input or tick.

Optional Feature:
- WASH_REVERSE_EN defined: during WASH RUN, every REV_TICKS ticks:
  - sub-ramp to MIN_VAL, toggle o_dir, ramp back to WASH_VAL;
  - the phase timer keeps counting during the reversal;
  - o_dir returns to 0 on entering RINSE.
- Undefined: o_dir is constant 0; no reversal logic is built.

Decomposition:
- Package wash_motor_pkg: state enum, phase codes (PH_WASH/PH_RINSE/PH_SPIN), 17-bit ramp-arithmetic width constant.
- Sub-module tick_gen: parameterised TICK_DIV divider with enable and clear, producing the tick pulse.

Test Plan (TICK_DIV=4, RAMP_STEP=100, RAMP_TICKS=1, MIN_VAL=1, targets 200/300/1000, all *_TICKS=5):
- Reset mid-RUN -> all outputs 0 immediately (asynchronous), state IDLE.
- i_start -> value 1, 101, 200 on successive ticks; RUN 5 ticks; ramp 300; RUN; ramp to 1000 in 7 steps; RUN; ramp down to 1; o_done pulses once; o_busy falls.
- i_stop during RINSE RUN -> STOP_RAMP, ramp down to 1, IDLE; o_done stays 0.
- i_pause held 20 cycles in WASH RUN at timer=3 -> o_pwm_en=0, value 200 held, timer stays 3; release -> 3 more ticks, then ramp to 300.
- i_start and i_stop in the same cycle from IDLE -> remains IDLE; i_start while busy -> no restart.
- Ramp boundary, target 1000 from 950 with RAMP_STEP=100 -> value 1000 exactly, no overshoot; o_pwm_value never 0 while o_pwm_en=1 (assertion).

Source files
------------

// File: rtl/wash_motor_pkg.sv
// Shared types and constants for the wash motor sequencer: FSM states, phase codes and
// the widened ramp arithmetic that keeps value steps from wrapping at 0xFFFF.
package wash_motor_pkg;

  localparam int VALUE_W = 16;
  localparam int RAMP_W  = VALUE_W + 1;
  localparam int PHASE_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAMP,
    ST_RUN,
    ST_STOP_RAMP,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    REV_NONE,
    REV_DOWN,
    REV_UP
  } rev_t;

  localparam logic [PHASE_W-1:0] PH_WASH  = 2'd0;
  localparam logic [PHASE_W-1:0] PH_RINSE = 2'd1;
  localparam logic [PHASE_W-1:0] PH_SPIN  = 2'd2;

  // One ramp step toward tgt; lands exactly on tgt when within one step, so it never overshoots.
  function automatic logic [VALUE_W-1:0] ramp_step(input logic [VALUE_W-1:0] cur,
                                                   input logic [VALUE_W-1:0] tgt,
                                                   input logic [RAMP_W-1:0]  step);
    logic [RAMP_W-1:0] c;
    logic [RAMP_W-1:0] t;
    logic [RAMP_W-1:0] r;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    r = t;
    if (t > c) begin
      if ((t - c) > step) r = c + step;
    end else if ((c - t) > step) begin
      r = c - step;
    end
    return r[VALUE_W-1:0];
  endfunction

endpackage

// File: rtl/wash_motor_seq_if.sv
// Command/status bundle between the MCU-facing control logic (master) and the sequencer (slave).
interface wash_motor_seq_if;
  import wash_motor_pkg::*;

  logic               i_start;
  logic               i_stop;
  logic               i_pause;
  logic               o_pwm_en;
  logic [VALUE_W-1:0] o_pwm_value;
  logic [PHASE_W-1:0] o_phase;
  logic               o_busy;
  logic               o_done;
  logic               o_dir;

  modport master (
    output i_start, i_stop, i_pause,
    input  o_pwm_en, o_pwm_value, o_phase, o_busy, o_done, o_dir
  );

  modport slave (
    input  i_start, i_stop, i_pause,
    output o_pwm_en, o_pwm_value, o_phase, o_busy, o_done, o_dir
  );

endinterface

// File: rtl/wash_motor_seq_tick_gen.sv
// tick_gen: free-running 0..TICK_DIV-1 divider with enable and clear; tick_o pulses on the last count.
module tick_gen #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
  end

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/wash_motor_seq.sv
// wash_motor_seq: runs WASH -> RINSE -> SPIN with soft ramps, driving a PWM generator's enable/value.
// Build option WASH_REVERSE_EN adds periodic direction reversal in WASH RUN; otherwise o_dir is tied 0.
module wash_motor_seq #(
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned RAMP_STEP   = 10,
  parameter int unsigned RAMP_TICKS  = 1,
  parameter int unsigned MIN_VAL     = 1,
  parameter int unsigned WASH_VAL    = 200,
  parameter int unsigned RINSE_VAL   = 300,
  parameter int unsigned SPIN_VAL    = 1000,
  parameter int unsigned WASH_TICKS  = 20000,
  parameter int unsigned RINSE_TICKS = 20000,
  parameter int unsigned SPIN_TICKS  = 30000
`ifdef WASH_REVERSE_EN
  ,
  parameter int unsigned REV_TICKS   = 5000
`endif
) (
  input  logic            i_clk,
  input  logic            i_reset,
  wash_motor_seq_if.slave bus
);
  import wash_motor_pkg::*;

  localparam logic [VALUE_W-1:0] MIN_V   = VALUE_W'(MIN_VAL);
  localparam logic [VALUE_W-1:0] WASH_V  = VALUE_W'(WASH_VAL);
  localparam logic [VALUE_W-1:0] RINSE_V = VALUE_W'(RINSE_VAL);
  localparam logic [VALUE_W-1:0] SPIN_V  = VALUE_W'(SPIN_VAL);
  localparam logic [RAMP_W-1:0]  STEP_V  = RAMP_W'(RAMP_STEP);

  state_t             state_q, state_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic [VALUE_W-1:0] target_q, target_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [31:0]        timer_q, timer_d;
  logic [31:0]        ramp_cnt_q, ramp_cnt_d;
  logic               abort_q, abort_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tick;
  logic               frozen;
  logic               ramp_tick;
  logic [VALUE_W-1:0] stepped;

`ifdef WASH_REVERSE_EN
  logic               dir_q, dir_d;
  rev_t               rev_q, rev_d;
  logic [31:0]        rev_cnt_q, rev_cnt_d;
`endif

  function automatic logic [31:0] phase_ticks(input logic [PHASE_W-1:0] ph);
    case (ph)
      PH_WASH:  return WASH_TICKS;
      PH_RINSE: return RINSE_TICKS;
      default:  return SPIN_TICKS;
    endcase
  endfunction

  // Pause only bites while the program is actively ramping or running; stop/finish ramps always complete.
  assign frozen  = bus.i_pause && ((state_q == ST_RAMP) || (state_q == ST_RUN));
  assign stepped = ramp_step(value_q, target_q, STEP_V);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (i_clk),
    .rst    (i_reset),
    .en_i   ((state_q != ST_IDLE) && !frozen),
    .clr_i  (state_q == ST_IDLE),
    .tick_o (tick)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      value_q    <= '0;
      target_q   <= '0;
      phase_q    <= PH_WASH;
      timer_q    <= '0;
      ramp_cnt_q <= '0;
      abort_q    <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      target_q   <= target_d;
      phase_q    <= phase_d;
      timer_q    <= timer_d;
      ramp_cnt_q <= ramp_cnt_d;
      abort_q    <= abort_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef WASH_REVERSE_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      dir_q     <= 1'b0;
      rev_q     <= REV_NONE;
      rev_cnt_q <= '0;
    end else begin
      dir_q     <= dir_d;
      rev_q     <= rev_d;
      rev_cnt_q <= rev_cnt_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    target_d   = target_q;
    phase_d    = phase_q;
    timer_d    = timer_q;
    ramp_cnt_d = ramp_cnt_q;
    abort_d    = abort_q;
    ramp_tick  = tick && (ramp_cnt_q == RAMP_TICKS - 1);
`ifdef WASH_REVERSE_EN
    dir_d      = dir_q;
    rev_d      = rev_q;
    rev_cnt_d  = rev_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.i_start && !bus.i_stop) begin
          state_d  = ST_RAMP;
          value_d  = MIN_V;
          target_d = WASH_V;
          phase_d  = PH_WASH;
          abort_d  = 1'b0;
        end
      end

      ST_RAMP, ST_STOP_RAMP: begin
        if ((state_q == ST_RAMP) && bus.i_stop) begin
          state_d  = ST_STOP_RAMP;
          target_d = MIN_V;
          abort_d  = 1'b1;
        end else if (!frozen) begin
          if (value_q == target_q) begin
            if (state_q == ST_RAMP) begin
              state_d = ST_RUN;
              timer_d = phase_ticks(phase_q);
            end else if (abort_q) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DONE;
            end
          end else if (tick) begin
            ramp_cnt_d = ramp_tick ? '0 : ramp_cnt_q + 32'd1;
            if (ramp_tick) value_d = stepped;
          end
        end
      end

      ST_RUN: begin
        if (bus.i_stop) begin
          state_d  = ST_STOP_RAMP;
          target_d = MIN_V;
          abort_d  = 1'b1;
        end else if (!frozen) begin
`ifdef WASH_REVERSE_EN
          // Reversal dips to MIN_VAL, flips direction, and climbs back while the phase timer keeps running.
          if (rev_q != REV_NONE) begin
            if (value_q == target_q) begin
              if (rev_q == REV_DOWN) begin
                rev_d    = REV_UP;
                dir_d    = ~dir_q;
                target_d = WASH_V;
              end else begin
                rev_d = REV_NONE;
              end
              ramp_cnt_d = '0;
            end else if (tick) begin
              ramp_cnt_d = ramp_tick ? '0 : ramp_cnt_q + 32'd1;
              if (ramp_tick) value_d = stepped;
            end
          end else if ((phase_q == PH_WASH) && tick) begin
            if (rev_cnt_q >= REV_TICKS - 1) begin
              rev_cnt_d  = '0;
              rev_d      = REV_DOWN;
              target_d   = MIN_V;
              ramp_cnt_d = '0;
            end else begin
              rev_cnt_d = rev_cnt_q + 32'd1;
            end
          end
`endif
          if (tick) begin
            timer_d = timer_q - 32'd1;
            if (timer_q <= 32'd1) begin
              timer_d = '0;
              case (phase_q)
                PH_WASH: begin
                  state_d  = ST_RAMP;
                  phase_d  = PH_RINSE;
                  target_d = RINSE_V;
                end
                PH_RINSE: begin
                  state_d  = ST_RAMP;
                  phase_d  = PH_SPIN;
                  target_d = SPIN_V;
                end
                default: begin
                  state_d  = ST_STOP_RAMP;
                  target_d = MIN_V;
                  abort_d  = 1'b0;
                end
              endcase
            end
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) ramp_cnt_d = '0;

    // The generator divides by the value word, so it is 0 only when disabled and floored at MIN_VAL otherwise.
    if ((state_d == ST_IDLE) || (state_d == ST_DONE)) begin
      value_d = '0;
      abort_d = 1'b0;
      if (state_d == ST_IDLE) phase_d = PH_WASH;
    end else if (value_d < MIN_V) begin
      value_d = MIN_V;
    end

`ifdef WASH_REVERSE_EN
    if (state_d != ST_RUN) begin
      rev_d     = REV_NONE;
      rev_cnt_d = '0;
    end
    if ((state_d == ST_IDLE) || (phase_d != PH_WASH)) dir_d = 1'b0;
`endif

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    en_d   = ((state_d == ST_RAMP) || (state_d == ST_RUN) || (state_d == ST_STOP_RAMP)) &&
             !(bus.i_pause && ((state_d == ST_RAMP) || (state_d == ST_RUN)));
  end

  assign bus.o_pwm_en    = en_q;
  assign bus.o_pwm_value = value_q;
  assign bus.o_phase     = phase_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
`ifdef WASH_REVERSE_EN
  assign bus.o_dir       = dir_q;
`else
  assign bus.o_dir       = 1'b0;
`endif

endmodule
